id_stage: RTL and testbench

ID_STAGE -- requirements
Module: id_stage

---
 rtl/id_stage.sv | 195 +++++++++++++++++++
 tb/tb_id_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// Instruction decode stage: one registered valid/ready slot that splits a MIPS word
// into fields and control bits. ID_STAGE_ILLEGAL_TRAP_EN enables the o_illegal flag.
module id_stage (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    output logic        o_ready,
    input  logic        i_out_ready,
    input  logic        i_flush,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [4:0]  o_rs,
    output logic [4:0]  o_rt,
    output logic [4:0]  o_wr_reg,
    output logic [4:0]  o_shamt,
    output logic [5:0]  o_funct,
    output logic [5:0]  o_opcode,
    output logic [15:0] o_imm,
    output logic        o_sign,
    output logic        o_reg_write,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_branch,
    output logic        o_jump,
    output logic        o_illegal
);

`ifdef ID_STAGE_ILLEGAL_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    localparam logic [4:0] LinkReg = 5'd31;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr_reg;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic        sign;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_out_t;

    id_out_t out_q, out_d, dec_c;
    logic    valid_q, valid_d;
    logic    known_c;

    // Combinational decode of the incoming word
    always_comb begin
        dec_c        = '0;
        known_c      = 1'b0;
        dec_c.pc     = i_pc;
        dec_c.opcode = i_instr[31:26];
        dec_c.rs     = i_instr[25:21];
        dec_c.rt     = i_instr[20:16];
        dec_c.shamt  = i_instr[10:6];
        dec_c.funct  = i_instr[5:0];
        dec_c.imm    = i_instr[15:0];
        case (i_instr[31:26])
            6'b000000: begin
                case (i_instr[5:0])
                    6'b000000, 6'b000010, 6'b000011,
                    6'b100000, 6'b100001, 6'b100010, 6'b100011,
                    6'b100100, 6'b100101, 6'b100110, 6'b100111,
                    6'b101010, 6'b101011: begin
                        known_c         = 1'b1;
                        dec_c.wr_reg    = i_instr[15:11];
                        dec_c.reg_write = 1'b1;
                    end
                    6'b001000: begin
                        known_c      = 1'b1;
                        dec_c.wr_reg = i_instr[15:11];
                        dec_c.jump   = 1'b1;
                    end
                    default: known_c = 1'b0;
                endcase
            end
            6'b000010: begin
                known_c    = 1'b1;
                dec_c.jump = 1'b1;
            end
            6'b000011: begin
                known_c         = 1'b1;
                dec_c.wr_reg    = LinkReg;
                dec_c.reg_write = 1'b1;
                dec_c.jump      = 1'b1;
            end
            6'b000100, 6'b000101: begin
                known_c      = 1'b1;
                dec_c.branch = 1'b1;
                dec_c.sign   = 1'b1;
            end
            6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
                known_c         = 1'b1;
                dec_c.wr_reg    = i_instr[20:16];
                dec_c.reg_write = 1'b1;
                dec_c.sign      = 1'b1;
            end
            6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
                known_c         = 1'b1;
                dec_c.wr_reg    = i_instr[20:16];
                dec_c.reg_write = 1'b1;
            end
            6'b100011: begin
                known_c         = 1'b1;
                dec_c.wr_reg    = i_instr[20:16];
                dec_c.reg_write = 1'b1;
                dec_c.mem_read  = 1'b1;
                dec_c.sign      = 1'b1;
            end
            6'b101011: begin
                known_c         = 1'b1;
                dec_c.mem_write = 1'b1;
                dec_c.sign      = 1'b1;
            end
            default: known_c = 1'b0;
        endcase
        // Writes to $0 are discarded, which also makes sll $0 a clean NOP
        if (dec_c.wr_reg == 5'd0) begin
            dec_c.reg_write = 1'b0;
        end
        if (!known_c) begin
            dec_c.wr_reg    = 5'd0;
            dec_c.sign      = 1'b0;
            dec_c.reg_write = 1'b0;
            dec_c.mem_read  = 1'b0;
            dec_c.mem_write = 1'b0;
            dec_c.branch    = 1'b0;
            dec_c.jump      = 1'b0;
            dec_c.illegal   = TrapEn;
        end
    end

    assign o_ready = !valid_q || i_out_ready;

    // Next state: flush beats accept, accept beats drain, otherwise hold
    always_comb begin
        valid_d = valid_q;
        out_d   = out_q;
        if (i_flush) begin
            valid_d         = 1'b0;
            out_d.reg_write = 1'b0;
            out_d.mem_read  = 1'b0;
            out_d.mem_write = 1'b0;
            out_d.branch    = 1'b0;
            out_d.jump      = 1'b0;
            out_d.illegal   = 1'b0;
        end else if (i_valid && o_ready) begin
            valid_d = 1'b1;
            out_d   = dec_c;
        end else if (i_out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q <= 1'b0;
            out_q   <= '0;
        end else begin
            valid_q <= valid_d;
            out_q   <= out_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_pc        = out_q.pc;
    assign o_opcode    = out_q.opcode;
    assign o_rs        = out_q.rs;
    assign o_rt        = out_q.rt;
    assign o_wr_reg    = out_q.wr_reg;
    assign o_shamt     = out_q.shamt;
    assign o_funct     = out_q.funct;
    assign o_imm       = out_q.imm;
    assign o_sign      = out_q.sign;
    assign o_reg_write = out_q.reg_write;
    assign o_mem_read  = out_q.mem_read;
    assign o_mem_write = out_q.mem_write;
    assign o_branch    = out_q.branch;
    assign o_jump      = out_q.jump;
    assign o_illegal   = out_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: accepted words queue their expected decode, a
// negedge monitor pops and compares on every output handshake.
module tb_id_stage;

`ifdef ID_STAGE_ILLEGAL_TRAP_EN
    localparam bit ILL = 1'b1;
`else
    localparam bit ILL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        i_rst, i_valid, i_out_ready, i_flush;
    logic [31:0] i_instr, i_pc;
    logic        o_ready, o_valid, o_sign, o_reg_write, o_mem_read, o_mem_write;
    logic        o_branch, o_jump, o_illegal;
    logic [31:0] o_pc;
    logic [4:0]  o_rs, o_rt, o_wr_reg, o_shamt;
    logic [5:0]  o_funct, o_opcode;
    logic [15:0] o_imm;

    always #5 clk = ~clk;

    id_stage dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_instr(i_instr), .i_pc(i_pc),
        .o_ready(o_ready), .i_out_ready(i_out_ready), .i_flush(i_flush),
        .o_valid(o_valid), .o_pc(o_pc), .o_rs(o_rs), .o_rt(o_rt), .o_wr_reg(o_wr_reg),
        .o_shamt(o_shamt), .o_funct(o_funct), .o_opcode(o_opcode), .o_imm(o_imm),
        .o_sign(o_sign), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
        .o_mem_write(o_mem_write), .o_branch(o_branch), .o_jump(o_jump), .o_illegal(o_illegal)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  opcode;
        logic [4:0]  rs, rt, wr, shamt;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [6:0]  ctl;  // {sign, reg_write, mem_read, mem_write, branch, jump, illegal}
    } exp_t;

    exp_t act;
    assign act = {o_pc, o_opcode, o_rs, o_rt, o_wr_reg, o_shamt, o_funct, o_imm,
                  o_sign, o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal};

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] a, input logic [127:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, a, e);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] pc, input logic [31:0] ins,
                                input logic [4:0] wr, input logic [6:0] ctl);
        mk = {pc, ins[31:26], ins[25:21], ins[20:16], wr, ins[10:6], ins[5:0], ins[15:0], ctl};
    endfunction

    // Monitor: every completed output handshake must match the oldest expectation
    always @(negedge clk) begin : monitor
        exp_t e;
        if (i_rst === 1'b0 && o_valid === 1'b1 && i_out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_output: got %h expected none", act);
            end else begin
                e = q.pop_front();
                chk("handshake_out", 128'(act), 128'(e));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input exp_t e);
        bit done = 1'b0;
        i_valid = 1'b1;
        i_instr = ins;
        i_pc    = pc;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (o_ready === 1'b1) begin
                @(posedge clk);
                q.push_back(e);
                done = 1'b1;
            end
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: got o_ready=%b expected 1 within 20 cycles", o_ready);
            @(posedge clk);
        end
        #1;
        i_valid = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "timeout");
    end

    localparam int NV = 8;
    logic [31:0] v_ins [NV];
    logic [4:0]  v_wr  [NV];
    logic [6:0]  v_ctl [NV];

    initial begin
        exp_t sw_e;
        // 0xFC000000 unknown op, NOP, add $3,$1,$2, jr $31, beq, j, funct 1, lui $1
        v_ins = '{32'hFC000000, 32'h00000000, 32'h00221820, 32'h03E00008,
                  32'h10220004, 32'h08000100, 32'h00000001, 32'h3C011234};
        v_wr  = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0, 5'd0, 5'd0, 5'd1};
        v_ctl = '{{6'b000000, ILL}, 7'b0000000, 7'b0100000, 7'b0000010,
                  7'b1000100, 7'b0000010, {6'b000000, ILL}, 7'b0100000};

        i_rst = 1'b1; i_valid = 1'b0; i_out_ready = 1'b1; i_flush = 1'b0;
        i_instr = '0; i_pc = '0;
        repeat (2) cyc();
        chk("reset_state", 128'(act), 128'(0));
        chk("reset_valid", 128'(o_valid), 128'(0));
        chk("reset_ready", 128'(o_ready), 128'(1));
        i_rst = 1'b0;

        send(32'h2008FFFF, 32'h400, mk(32'h400, 32'h2008FFFF, 5'd8, 7'b1100000));
        chk("addi_latency", 128'({o_valid, o_imm, o_sign, o_wr_reg}), 128'({1'b1, 16'hFFFF, 1'b1, 5'd8}));
        send(32'h3508FFFF, 32'h404, mk(32'h404, 32'h3508FFFF, 5'd8, 7'b0100000));

        send(32'h8D090004, 32'h408, mk(32'h408, 32'h8D090004, 5'd9, 7'b1110000));
        chk("lw_mem_read", 128'({o_valid, o_mem_read}), 128'(2'b11));
        sw_e = mk(32'h40C, 32'hAD090008, 5'd0, 7'b1001000);
        send(32'hAD090008, 32'h40C, sw_e);
        chk("sw_no_bubble", 128'({o_valid, o_mem_write}), 128'(2'b11));
        i_out_ready = 1'b0;
        repeat (3) begin
            cyc();
            chk("stall_hold", 128'({o_valid, act}), 128'({1'b1, sw_e}));
            chk("stall_ready", 128'(o_ready), 128'(0));
        end
        i_out_ready = 1'b1;
        cyc();

        send(32'h0C000010, 32'h410, mk(32'h410, 32'h0C000010, 5'd31, 7'b0100010));
        cyc();
        chk("drain_valid_drop", 128'(o_valid), 128'(0));
        chk("drain_hold", 128'({o_wr_reg, o_jump, o_pc}), 128'({5'd31, 1'b1, 32'h410}));

        for (int i = 0; i < NV; i++) begin
            send(v_ins[i], 32'h1000 + 32'(4 * i), mk(32'h1000 + 32'(4 * i), v_ins[i], v_wr[i], v_ctl[i]));
        end
        repeat (2) cyc();

        i_out_ready = 1'b0;
        send(32'h2008FFFF, 32'h500, mk(32'h500, 32'h2008FFFF, 5'd8, 7'b1100000));
        chk("flush_pre_held", 128'(o_valid), 128'(1));
        i_valid = 1'b1; i_instr = 32'h8D090004; i_pc = 32'h504; i_flush = 1'b1;
        cyc();
        i_flush = 1'b0; i_valid = 1'b0;
        void'(q.pop_back());
        chk("flush_valid", 128'(o_valid), 128'(0));
        chk("flush_ctl", 128'({o_reg_write, o_mem_read, o_mem_write, o_branch, o_jump, o_illegal}), 128'(0));
        cyc();
        chk("flush_no_accept", 128'(o_valid), 128'(0));

        send(32'h2008FFFF, 32'h600, mk(32'h600, 32'h2008FFFF, 5'd8, 7'b1100000));
        chk("rst_pre_held", 128'({o_valid, o_sign}), 128'(2'b11));
        i_rst = 1'b1;
        cyc();
        void'(q.pop_back());
        chk("rst_stall", 128'({o_valid, o_imm, o_sign, o_pc}), 128'(0));
        i_rst = 1'b0;
        i_out_ready = 1'b1;

        send(32'h3508FFFF, 32'h700, mk(32'h700, 32'h3508FFFF, 5'd8, 7'b0100000));
        repeat (2) cyc();
        chk("queue_empty", 128'(q.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
